regfile_wb_ctrl: RTL and testbench

Write-port controller for the 32 x 32-bit integer register file. Shares the file's single write port among several writeback requesters using round-robin arbitration, and keeps a pending-write scoreboard so issue logic can stall on read-after-write hazards. Sits between the execute/memory/multi-cycle units and the register file write port (we, A3, wd3).

---
 rtl/regfile_ctrl_pkg.sv | 16 +
 rtl/regfile_wb_ctrl_rr_arbiter.sv | 32 +++
 rtl/regfile_wb_ctrl.sv | 114 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and sizes for the register-file write-port controller.
package regfile_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One writeback as presented by a requester.
  typedef struct packed {
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr,
// wrapping around; grant is one-hot or all zero.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic found;

  // Two passes: indices ptr..N-1 first, then the wrapped range 0..ptr-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: round-robin sharing of the single
// write port among writeback requesters, plus a pending-write scoreboard
// that issue logic uses to stall on read-after-write hazards.
module regfile_wb_ctrl #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              rsv_valid,
  input  logic [REG_ADDR_W-1:0]             rsv_addr,
  output logic                              rsv_conflict,
  input  logic [REG_ADDR_W-1:0]             rs1_addr,
  input  logic [REG_ADDR_W-1:0]             rs2_addr,
  output logic                              rs1_busy,
  output logic                              rs2_busy,
  output logic                              rf_we,
  output logic [REG_ADDR_W-1:0]             rf_a3,
  output logic [XLEN-1:0]                   rf_wd3
);

  import regfile_ctrl_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 1 << REG_ADDR_W;

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_any;
  logic [PTR_W-1:0]      win_idx;
  wb_req_t               win;

  logic                  rf_we_q,  rf_we_d;
  logic [REG_ADDR_W-1:0] rf_a3_q,  rf_a3_d;
  logic [XLEN-1:0]       rf_wd3_q, rf_wd3_d;
  logic [NREG-1:0]       pend_q,   pend_d;

  rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (gnt)
  );

  assign req_ready = gnt;
  assign gnt_any   = |gnt;

  // Select the winning requester's index and payload from the one-hot grant.
  always_comb begin
    win_idx = '0;
    win     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_idx   = PTR_W'(i);
        win.addr  = req_addr[i];
        win.data  = req_data[i];
      end
    end
  end

  // Next-state: pointer advances past the winner; writeback reg loads on grant;
  // scoreboard clears the retiring write, then sets the new reservation so a
  // same-address set beats the clear.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd3_d = rf_wd3_q;
    pend_d   = pend_q;
    if (gnt_any) begin
      rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
      rf_we_d  = (win.addr != '0);
      rf_a3_d  = win.addr;
      rf_wd3_d = win.data;
    end
    if (rf_we_q)
      pend_d[rf_a3_q] = 1'b0;
    if (rsv_valid && (rsv_addr != '0))
      pend_d[rsv_addr] = 1'b1;
  end

  // State registers; asynchronous reset drops any in-flight write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd3_q <= '0;
      pend_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd3_q <= rf_wd3_d;
      pend_q   <= pend_d;
    end
  end

  assign rf_we  = rf_we_q;
  assign rf_a3  = rf_a3_q;
  assign rf_wd3 = rf_wd3_q;

  assign rs1_busy = pend_q[rs1_addr] && (rs1_addr != '0);
  assign rs2_busy = pend_q[rs2_addr] && (rs2_addr != '0);

  // Advisory only: a write retiring this cycle to the same register hides it.
  assign rsv_conflict = rsv_valid && (rsv_addr != '0) && pend_q[rsv_addr] &&
                        !(rf_we_q && (rf_a3_q == rsv_addr));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed vector bench for regfile_wb_ctrl (NUM_REQ=3).
module tb_regfile_wb_ctrl;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        req_valid;
  logic [2:0][4:0]   req_addr;
  logic [2:0][31:0]  req_data;
  logic [2:0]        req_ready;
  logic              rsv_valid;
  logic [4:0]        rsv_addr;
  logic              rsv_conflict;
  logic [4:0]        rs1_addr, rs2_addr;
  logic              rs1_busy, rs2_busy;
  logic              rf_we;
  logic [4:0]        rf_a3;
  logic [31:0]       rf_wd3;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.NUM_REQ(3), .XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_conflict(rsv_conflict),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  typedef struct {
    logic             rst;
    logic [2:0]       v;
    logic [2:0][4:0]  a;
    logic [2:0][31:0] d;
    logic             rv;
    logic [4:0]       ra, r1, r2;
    logic [2:0]       rdy;
    logic             cf, b1, b2, we;
    logic [4:0]       a3;
    logic [31:0]      wd;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    logic rst, logic [2:0] v,
    logic [4:0] a0, logic [31:0] d0, logic [4:0] a1, logic [31:0] d1, logic [4:0] a2, logic [31:0] d2,
    logic rv, logic [4:0] ra, logic [4:0] r1, logic [4:0] r2,
    logic [2:0] rdy, logic cf, logic b1, logic b2, logic we, logic [4:0] a3, logic [31:0] wd);
    vec_t t;
    t.rst = rst; t.v = v;
    t.a[0] = a0; t.d[0] = d0; t.a[1] = a1; t.d[1] = d1; t.a[2] = a2; t.d[2] = d2;
    t.rv = rv; t.ra = ra; t.r1 = r1; t.r2 = r2;
    t.rdy = rdy; t.cf = cf; t.b1 = b1; t.b2 = b2; t.we = we; t.a3 = a3; t.wd = wd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset     = t.rst;
    req_valid = t.v;
    req_addr  = t.a;
    req_data  = t.d;
    rsv_valid = t.rv;
    rsv_addr  = t.ra;
    rs1_addr  = t.r1;
    rs2_addr  = t.r2;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; rs1_addr = '0; rs2_addr = '0;

    //            rst v       a0 d0            a1 d1      a2 d2      rv ra r1 r2  rdy    cf b1 b2 we a3 wd
    tv.push_back(mk(1, 3'b000, 0, 0,            0, 0,      0, 0,      0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    // single requester
    tv.push_back(mk(0, 3'b001, 5, 32'hDEADBEEF, 0, 0,      0, 0,      0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 3'b000, 0, 0,            0, 0,      0, 0,      0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 5, 32'hDEADBEEF));
    // req2 alone: pointer wraps back to 0
    tv.push_back(mk(0, 3'b100, 0, 0,            0, 0,      10, 32'hA2, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 5, 32'hDEADBEEF));
    // full contention: 0,1,2,0,1,2
    tv.push_back(mk(0, 3'b111, 11, 32'hA0,      12, 32'hA1, 13, 32'hA2, 0, 0, 0, 0, 3'b001, 0, 0, 0, 1, 10, 32'hA2));
    tv.push_back(mk(0, 3'b111, 11, 32'hA0,      12, 32'hA1, 13, 32'hA2, 0, 0, 0, 0, 3'b010, 0, 0, 0, 1, 11, 32'hA0));
    tv.push_back(mk(0, 3'b111, 11, 32'hA0,      12, 32'hA1, 13, 32'hA2, 0, 0, 0, 0, 3'b100, 0, 0, 0, 1, 12, 32'hA1));
    tv.push_back(mk(0, 3'b111, 11, 32'hA0,      12, 32'hA1, 13, 32'hA2, 0, 0, 0, 0, 3'b001, 0, 0, 0, 1, 13, 32'hA2));
    tv.push_back(mk(0, 3'b111, 11, 32'hA0,      12, 32'hA1, 13, 32'hA2, 0, 0, 0, 0, 3'b010, 0, 0, 0, 1, 11, 32'hA0));
    tv.push_back(mk(0, 3'b111, 11, 32'hA0,      12, 32'hA1, 13, 32'hA2, 0, 0, 0, 0, 3'b100, 0, 0, 0, 1, 12, 32'hA1));
    // req1 dropped: 0,2,0,2
    tv.push_back(mk(0, 3'b101, 11, 32'hA0,      0, 0,      13, 32'hA2, 0, 0, 0, 0, 3'b001, 0, 0, 0, 1, 13, 32'hA2));
    tv.push_back(mk(0, 3'b101, 11, 32'hA0,      0, 0,      13, 32'hA2, 0, 0, 0, 0, 3'b100, 0, 0, 0, 1, 11, 32'hA0));
    tv.push_back(mk(0, 3'b101, 11, 32'hA0,      0, 0,      13, 32'hA2, 0, 0, 0, 0, 3'b001, 0, 0, 0, 1, 13, 32'hA2));
    tv.push_back(mk(0, 3'b101, 11, 32'hA0,      0, 0,      13, 32'hA2, 0, 0, 0, 0, 3'b100, 0, 0, 0, 1, 11, 32'hA0));
    tv.push_back(mk(0, 3'b000, 0, 0,            0, 0,      0, 0,      0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 13, 32'hA2));
    // scoreboard on x7: reserve, write back at N, busy through N+1, clear at N+2
    tv.push_back(mk(0, 3'b000, 0, 0,            0, 0,      0, 0,      1, 7, 7, 0, 3'b000, 0, 0, 0, 0, 13, 32'hA2));
    tv.push_back(mk(0, 3'b001, 7, 32'h77,       0, 0,      0, 0,      0, 0, 7, 0, 3'b001, 0, 1, 0, 0, 13, 32'hA2));
    tv.push_back(mk(0, 3'b000, 0, 0,            0, 0,      0, 0,      0, 0, 7, 0, 3'b000, 0, 1, 0, 1, 7, 32'h77));
    tv.push_back(mk(0, 3'b000, 0, 0,            0, 0,      0, 0,      0, 0, 7, 0, 3'b000, 0, 0, 0, 0, 7, 32'h77));
    // x9: reserve with writeback accepted, then same-cycle set/clear, then re-reserve
    tv.push_back(mk(0, 3'b001, 9, 32'h99,       0, 0,      0, 0,      1, 9, 9, 0, 3'b001, 0, 0, 0, 0, 7, 32'h77));
    tv.push_back(mk(0, 3'b000, 0, 0,            0, 0,      0, 0,      1, 9, 9, 0, 3'b000, 0, 1, 0, 1, 9, 32'h99));
    tv.push_back(mk(0, 3'b000, 0, 0,            0, 0,      0, 0,      1, 9, 9, 0, 3'b000, 1, 1, 0, 0, 9, 32'h99));
    tv.push_back(mk(0, 3'b000, 0, 0,            0, 0,      0, 0,      0, 0, 9, 9, 3'b000, 0, 1, 1, 0, 9, 32'h99));
    // x0 writeback: consumed, no write
    tv.push_back(mk(0, 3'b010, 0, 0,            0, 32'h1234, 0, 0,    0, 0, 9, 0, 3'b010, 0, 1, 0, 0, 9, 32'h99));
    tv.push_back(mk(0, 3'b000, 0, 0,            0, 0,      0, 0,      1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h1234));

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d.ready", i),    req_ready,    tv[i].rdy);
      chk($sformatf("v%0d.conflict", i), rsv_conflict, tv[i].cf);
      chk($sformatf("v%0d.rs1_busy", i), rs1_busy,     tv[i].b1);
      chk($sformatf("v%0d.rs2_busy", i), rs2_busy,     tv[i].b2);
      chk($sformatf("v%0d.rf_we", i),    rf_we,        tv[i].we);
      chk($sformatf("v%0d.rf_a3", i),    rf_a3,        tv[i].a3);
      chk($sformatf("v%0d.rf_wd3", i),   rf_wd3,       tv[i].wd);
    end

    // Reset mid-operation: rr_ptr=2 (x0 grant went to req1), build pend[3]=1 and rf_we=1.
    @(negedge clk);
    req_valid = 3'b010; req_addr[1] = 5'd21; req_data[1] = 32'h21;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    #1 chk("rst.pre_ready", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0; rsv_valid = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd9;
    #1;
    chk("rst.pre_we",  rf_we,    1);
    chk("rst.pre_a3",  rf_a3,    21);
    chk("rst.pre_b1",  rs1_busy, 1);
    chk("rst.pre_b2",  rs2_busy, 1);
    reset = 1'b1;
    #1;
    chk("rst.we",  rf_we,    0);
    chk("rst.a3",  rf_a3,    0);
    chk("rst.wd3", rf_wd3,   0);
    chk("rst.b1",  rs1_busy, 0);
    chk("rst.b2",  rs2_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 3'b111;
    req_addr[0] = 5'd1; req_data[0] = 32'h101;
    req_addr[1] = 5'd2; req_data[1] = 32'h202;
    req_addr[2] = 5'd4; req_data[2] = 32'h404;
    #1 chk("post.ready0", req_ready, 3'b001);
    @(negedge clk);
    #1;
    chk("post.ready1", req_ready, 3'b010);
    chk("post.we",     rf_we,     1);
    chk("post.a3",     rf_a3,     1);
    chk("post.wd3",    rf_wd3,    32'h101);
    req_valid = '0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
